memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/memory_stage_if.sv | 23 ++
 rtl/load_align.sv | 30 +++
 rtl/memory_stage.sv | 162 ++++++++++++++++
 tb/tb_memory_stage.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: opcodes, load/store funct3 codes,
// FSM state type and access-size helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_D  = 3'd3;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  localparam logic [2:0] F3_WU = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  // funct3[1:0] encodes the access size for both loads and stores
  function automatic logic [7:0] size_be(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response bus between the memory stage (master)
// and the data memory (slave).
interface memory_stage_if;

  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [63:0] DMEM_ADDR;
  logic [63:0] DMEM_WDATA;
  logic [7:0]  DMEM_BE;
  logic [63:0] DMEM_RDATA;
  logic        DMEM_ACK;

  modport master (
    output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
    input  DMEM_RDATA, DMEM_ACK
  );

  modport slave (
    input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA, DMEM_BE,
    output DMEM_RDATA, DMEM_ACK
  );

endinterface

// File: rtl/load_align.sv
// Picks the loaded lane out of a 64-bit memory word at the byte offset and
// sign- or zero-extends it according to the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  offset,
  input  logic [2:0]  funct3,
  output logic [63:0] data
);

  logic [63:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{56{lane[7]}},  lane[7:0]};
      F3_H:    data = {{48{lane[15]}}, lane[15:0]};
      F3_W:    data = {{32{lane[31]}}, lane[31:0]};
      F3_D:    data = lane;
      F3_BU:   data = {56'd0, lane[7:0]};
      F3_HU:   data = {48'd0, lane[15:0]};
      F3_WU:   data = {32'd0, lane[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: issues aligned loads/stores on the data-memory bus,
// stalls execute until the access completes, and registers the writeback bundle.
//
// state  | meaning
// IDLE   | accept next instruction; pass-through or start an access
// ACCESS | request held on the bus, waiting for DMEM_ACK
// DONE   | load data captured; writeback latched at the next edge
module memory_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic        MEM_ECALL,
  input  logic [31:0] MEM_IR,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_ALU_RESULT,
  input  logic [63:0] MEM_SR2,
  input  logic [63:0] MEM_CSRFD,
  input  logic [63:0] MEM_RFD,
  output logic        MEM_STALL,
  memory_stage_if.master dmem,
  output logic        WB_V,
  output logic        WB_ECALL,
  output logic        WB_MISALIGN,
  output logic [31:0] WB_IR,
  output logic [63:0] WB_NPC,
  output logic [63:0] WB_ALU_RESULT,
  output logic [63:0] WB_MEM_DATA,
  output logic [63:0] WB_CSRFD,
  output logic [63:0] WB_RFD
);

  mem_state_e  state_q, state_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [2:0]  offset;
  logic        is_load, is_store, mem_op, misalign;
  logic        stall, start, ack_take, wb_v_d, wb_mis_d;
  logic [63:0] sr2_m, st_wdata, ld_aligned, ld_data_q;
  logic [7:0]  acc_be;

  assign opcode   = MEM_IR[6:0];
  assign funct3   = MEM_IR[14:12];
  assign offset   = MEM_ALU_RESULT[2:0];

  // Undefined funct3 codes fall out here and are treated as pass-through
  assign is_load  = MEM_V && (opcode == OPC_LOAD) && (funct3 != 3'd7);
  assign is_store = MEM_V && (opcode == OPC_STORE) && !funct3[2];
  assign mem_op   = is_load || is_store;
  assign misalign = (offset & align_mask(funct3[1:0])) != 3'b000;

  always_comb begin
    sr2_m = '0;
    case (funct3[1:0])
      2'd0:    sr2_m = {56'd0, MEM_SR2[7:0]};
      2'd1:    sr2_m = {48'd0, MEM_SR2[15:0]};
      2'd2:    sr2_m = {32'd0, MEM_SR2[31:0]};
      default: sr2_m = MEM_SR2;
    endcase
  end

  assign st_wdata = sr2_m << {offset, 3'b000};
  assign acc_be   = size_be(funct3[1:0]) << offset;

  load_align u_load_align (
    .rdata  (dmem.DMEM_RDATA),
    .offset (offset),
    .funct3 (funct3),
    .data   (ld_aligned)
  );

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    start    = 1'b0;
    ack_take = 1'b0;
    wb_v_d   = 1'b0;
    wb_mis_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign) begin
          stall   = 1'b1;
          start   = 1'b1;
          state_d = ACCESS;
        end else begin
          wb_v_d   = MEM_V;
          wb_mis_d = mem_op;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem.DMEM_ACK) begin
          ack_take = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        wb_v_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated so that reset forces the stall low even with a memory op on the inputs
  assign MEM_STALL = stall && !RESET;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      dmem.DMEM_REQ   <= 1'b0;
      dmem.DMEM_WE    <= 1'b0;
      dmem.DMEM_ADDR  <= '0;
      dmem.DMEM_WDATA <= '0;
      dmem.DMEM_BE    <= '0;
    end else if (start) begin
      dmem.DMEM_REQ   <= 1'b1;
      dmem.DMEM_WE    <= is_store;
      dmem.DMEM_ADDR  <= {MEM_ALU_RESULT[63:3], 3'b000};
      dmem.DMEM_WDATA <= is_store ? st_wdata : 64'd0;
      dmem.DMEM_BE    <= acc_be;
    end else if (ack_take) begin
      dmem.DMEM_REQ   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET)         ld_data_q <= '0;
    else if (ack_take) ld_data_q <= is_load ? ld_aligned : 64'd0;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      WB_V          <= 1'b0;
      WB_ECALL      <= 1'b0;
      WB_MISALIGN   <= 1'b0;
      WB_IR         <= '0;
      WB_NPC        <= '0;
      WB_ALU_RESULT <= '0;
      WB_MEM_DATA   <= '0;
      WB_CSRFD      <= '0;
      WB_RFD        <= '0;
    end else begin
      WB_V          <= wb_v_d;
      WB_ECALL      <= MEM_ECALL;
      WB_MISALIGN   <= wb_mis_d;
      WB_IR         <= MEM_IR;
      WB_NPC        <= MEM_NPC;
      WB_ALU_RESULT <= MEM_ALU_RESULT;
      WB_MEM_DATA   <= (state_q == DONE) ? ld_data_q : 64'd0;
      WB_CSRFD      <= MEM_CSRFD;
      WB_RFD        <= MEM_RFD;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: loads, stores, misalignment, pass-through,
// back-to-back flow and reset during an outstanding access.
module tb_memory_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        RESET;
  logic        MEM_V, MEM_ECALL;
  logic [31:0] MEM_IR;
  logic [63:0] MEM_NPC, MEM_ALU_RESULT, MEM_SR2, MEM_CSRFD, MEM_RFD;
  logic        MEM_STALL;
  logic        WB_V, WB_ECALL, WB_MISALIGN;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_DATA, WB_CSRFD, WB_RFD;

  localparam logic [6:0] OPC_ADD = 7'b0110011;

  memory_stage_if dmem ();

  memory_stage dut (
    .clk            (clk),
    .RESET          (RESET),
    .MEM_V          (MEM_V),
    .MEM_ECALL      (MEM_ECALL),
    .MEM_IR         (MEM_IR),
    .MEM_NPC        (MEM_NPC),
    .MEM_ALU_RESULT (MEM_ALU_RESULT),
    .MEM_SR2        (MEM_SR2),
    .MEM_CSRFD      (MEM_CSRFD),
    .MEM_RFD        (MEM_RFD),
    .MEM_STALL      (MEM_STALL),
    .dmem           (dmem),
    .WB_V           (WB_V),
    .WB_ECALL       (WB_ECALL),
    .WB_MISALIGN    (WB_MISALIGN),
    .WB_IR          (WB_IR),
    .WB_NPC         (WB_NPC),
    .WB_ALU_RESULT  (WB_ALU_RESULT),
    .WB_MEM_DATA    (WB_MEM_DATA),
    .WB_CSRFD       (WB_CSRFD),
    .WB_RFD         (WB_RFD)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic set_op(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] sr2);
    MEM_V          = v;
    MEM_ECALL      = 1'b0;
    MEM_IR         = mk_ir(opc, f3);
    MEM_ALU_RESULT = addr;
    MEM_SR2        = sr2;
    MEM_NPC        = addr + 64'h4;
    MEM_CSRFD      = ~addr;
    MEM_RFD        = addr ^ 64'hA5A5;
  endtask

  // Called at posedge+1 with a memory op already on the inputs; returns at
  // posedge+1 right after the writeback edge.
  task automatic mem_txn(input string tag, input int ack_at, input logic [63:0] rdata,
                         input logic [63:0] e_addr, input logic [63:0] e_wdata,
                         input logic [7:0] e_be, input logic e_we, input int e_stalls);
    int stalls;
    stalls = 0;
    #1;
    if (MEM_STALL) stalls++;
    check_eq({tag, ".req_idle"}, dmem.DMEM_REQ, 64'd0);
    for (int k = 1; k <= ack_at; k++) begin
      tick();
      check_eq({tag, ".req"},   dmem.DMEM_REQ,   64'd1);
      check_eq({tag, ".addr"},  dmem.DMEM_ADDR,  e_addr);
      check_eq({tag, ".wdata"}, dmem.DMEM_WDATA, e_wdata);
      check_eq({tag, ".be"},    dmem.DMEM_BE,    {56'd0, e_be});
      check_eq({tag, ".we"},    dmem.DMEM_WE,    {63'd0, e_we});
      check_eq({tag, ".wbv_acc"}, WB_V, 64'd0);
      if (k == ack_at) begin
        dmem.DMEM_RDATA = rdata;
        dmem.DMEM_ACK   = 1'b1;
      end
      #1;
      if (MEM_STALL) stalls++;
    end
    tick();
    dmem.DMEM_ACK   = 1'b0;
    dmem.DMEM_RDATA = 64'hBAD0_BAD0_BAD0_BAD0;
    check_eq({tag, ".req_done"}, dmem.DMEM_REQ, 64'd0);
    check_eq({tag, ".wbv_done"}, WB_V, 64'd0);
    #1;
    if (MEM_STALL) stalls++;
    check_eq({tag, ".stalls"}, stalls, e_stalls);
    tick();
    check_eq({tag, ".wbv"}, WB_V, 64'd1);
    check_eq({tag, ".mis"}, WB_MISALIGN, 64'd0);
  endtask

  task automatic pass_check(input string tag, input logic e_v, input logic e_mis);
    #1;
    check_eq({tag, ".stall"}, MEM_STALL, 64'd0);
    tick();
    check_eq({tag, ".req"}, dmem.DMEM_REQ, 64'd0);
    check_eq({tag, ".wbv"}, WB_V, {63'd0, e_v});
    check_eq({tag, ".mis"}, WB_MISALIGN, {63'd0, e_mis});
    check_eq({tag, ".data"}, WB_MEM_DATA, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    dmem.DMEM_ACK   = 1'b0;
    dmem.DMEM_RDATA = '0;
    set_op(1'b1, OPC_LOAD, F3_D, 64'h1000, 64'd0);
    #2;
    check_eq("rst.stall", MEM_STALL, 64'd0);
    check_eq("rst.req",   dmem.DMEM_REQ, 64'd0);
    check_eq("rst.wbv",   WB_V, 64'd0);
    tick();
    tick();
    check_eq("rst.req2",  dmem.DMEM_REQ, 64'd0);
    check_eq("rst.addr",  dmem.DMEM_ADDR, 64'd0);
    check_eq("rst.data",  WB_MEM_DATA, 64'd0);
    RESET = 1'b0;

    // LD held across reset release starts at the first edge with RESET low
    mem_txn("ld", 1, 64'h1122334455667788, 64'h1000, 64'd0, 8'hFF, 1'b0, 2);
    check_eq("ld.data", WB_MEM_DATA, 64'h1122334455667788);
    check_eq("ld.npc",  WB_NPC, 64'h1004);
    check_eq("ld.alu",  WB_ALU_RESULT, 64'h1000);
    check_eq("ld.ir",   WB_IR, 64'h0000_3003);
    check_eq("ld.rfd",  WB_RFD, 64'h1000 ^ 64'hA5A5);

    set_op(1'b1, OPC_LOAD, F3_B, 64'h1003, 64'd0);
    mem_txn("lb", 1, 64'h0000000080000000, 64'h1000, 64'd0, 8'h08, 1'b0, 2);
    check_eq("lb.data", WB_MEM_DATA, 64'hFFFFFFFFFFFFFF80);

    set_op(1'b1, OPC_LOAD, F3_BU, 64'h1003, 64'd0);
    mem_txn("lbu", 1, 64'h0000000080000000, 64'h1000, 64'd0, 8'h08, 1'b0, 2);
    check_eq("lbu.data", WB_MEM_DATA, 64'h0000000000000080);

    set_op(1'b1, OPC_LOAD, F3_H, 64'h1006, 64'd0);
    mem_txn("lh", 1, 64'h8001000000000000, 64'h1000, 64'd0, 8'hC0, 1'b0, 2);
    check_eq("lh.data", WB_MEM_DATA, 64'hFFFFFFFFFFFF8001);

    set_op(1'b1, OPC_LOAD, F3_WU, 64'h1004, 64'd0);
    mem_txn("lwu", 2, 64'hDEADBEEF00000000, 64'h1000, 64'd0, 8'hF0, 1'b0, 3);
    check_eq("lwu.data", WB_MEM_DATA, 64'h00000000DEADBEEF);

    set_op(1'b1, OPC_LOAD, F3_W, 64'h1004, 64'd0);
    mem_txn("lw", 1, 64'hDEADBEEF00000000, 64'h1000, 64'd0, 8'hF0, 1'b0, 2);
    check_eq("lw.data", WB_MEM_DATA, 64'hFFFFFFFFDEADBEEF);

    set_op(1'b1, OPC_STORE, F3_H, 64'h2006, 64'h000000000000ABCD);
    mem_txn("sh", 4, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2000, 64'hABCD000000000000, 8'hC0, 1'b1, 5);
    check_eq("sh.data", WB_MEM_DATA, 64'd0);

    set_op(1'b1, OPC_STORE, F3_B, 64'h2005, 64'h0000000012345677);
    mem_txn("sb", 1, 64'd0, 64'h2000, 64'h0000770000000000, 8'h20, 1'b1, 2);

    set_op(1'b1, OPC_STORE, F3_D, 64'h2008, 64'h0123456789ABCDEF);
    mem_txn("sd", 1, 64'd0, 64'h2008, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 2);

    set_op(1'b1, OPC_LOAD, F3_W, 64'h3002, 64'd0);
    pass_check("lw_mis", 1'b1, 1'b1);
    set_op(1'b1, OPC_STORE, F3_D, 64'h2004, 64'd0);
    pass_check("sd_mis", 1'b1, 1'b1);

    set_op(1'b1, OPC_LOAD, 3'd7, 64'h1000, 64'd0);
    pass_check("ld_f3x", 1'b1, 1'b0);
    set_op(1'b1, OPC_STORE, 3'd5, 64'h1000, 64'd0);
    pass_check("st_f3x", 1'b1, 1'b0);
    set_op(1'b0, OPC_LOAD, F3_D, 64'h1000, 64'd0);
    pass_check("ld_nov", 1'b0, 1'b0);

    // ADD, LD, ADD with an immediate ACK; a stray ACK during the first ADD
    set_op(1'b1, OPC_ADD, 3'd0, 64'h55, 64'd0);
    dmem.DMEM_ACK = 1'b1;
    tick();
    dmem.DMEM_ACK = 1'b0;
    check_eq("seq0.wbv", WB_V, 64'd1);
    check_eq("seq0.alu", WB_ALU_RESULT, 64'h55);
    check_eq("seq0.req", dmem.DMEM_REQ, 64'd0);
    set_op(1'b1, OPC_LOAD, F3_D, 64'h1008, 64'd0);
    tick();
    check_eq("seq1.wbv", WB_V, 64'd0);
    check_eq("seq1.req", dmem.DMEM_REQ, 64'd1);
    dmem.DMEM_RDATA = 64'hCAFE;
    dmem.DMEM_ACK   = 1'b1;
    tick();
    dmem.DMEM_ACK = 1'b0;
    check_eq("seq2.wbv", WB_V, 64'd0);
    tick();
    check_eq("seq3.wbv",  WB_V, 64'd1);
    check_eq("seq3.data", WB_MEM_DATA, 64'hCAFE);
    set_op(1'b1, OPC_ADD, 3'd0, 64'h77, 64'd0);
    tick();
    check_eq("seq4.wbv", WB_V, 64'd1);
    check_eq("seq4.alu", WB_ALU_RESULT, 64'h77);
    check_eq("seq4.data", WB_MEM_DATA, 64'd0);

    // Reset while the access is outstanding; the late ACK must be ignored
    set_op(1'b1, OPC_LOAD, F3_D, 64'h1010, 64'd0);
    tick();
    check_eq("rsta.req", dmem.DMEM_REQ, 64'd1);
    #2;
    RESET = 1'b1;
    #1;
    check_eq("rsta.req0",   dmem.DMEM_REQ, 64'd0);
    check_eq("rsta.stall0", MEM_STALL, 64'd0);
    set_op(1'b0, OPC_ADD, 3'd0, 64'd0, 64'd0);
    tick();
    RESET = 1'b0;
    dmem.DMEM_RDATA = 64'h1234;
    dmem.DMEM_ACK   = 1'b1;
    tick();
    dmem.DMEM_ACK = 1'b0;
    check_eq("rsta.wbv1", WB_V, 64'd0);
    check_eq("rsta.req1", dmem.DMEM_REQ, 64'd0);
    tick();
    check_eq("rsta.wbv2", WB_V, 64'd0);
    check_eq("rsta.data", WB_MEM_DATA, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
